// File: rtl/bit_sync_dco.sv
// Digitally controlled oscillator for the receive bit-synchroniser DPLL.
// Divides clk_high down to the local bit clock and slips its phase on loop-filter requests.
module bit_sync_dco #(
   parameter int DIV   = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk_high,
   input  logic             rst,
   input  logic             ahead_in,
   input  logic             behind_in,
   output logic             clk_local,
   output logic             bit_tick,
   output logic             adv_ack,
   output logic             ret_ack,
   output logic [CNT_W-1:0] phase
);

   localparam logic [CNT_W:0] DIV_W  = (CNT_W + 1)'(DIV);
   localparam logic [CNT_W:0] HALF_W = (CNT_W + 1)'(DIV / 2);

   // [0],[1] form the synchroniser; [2] is the edge-detect history.
   logic [2:0]       a_sync_q;
   logic [2:0]       b_sync_q;
   logic             pend_a_q, pend_a_d;
   logic             pend_b_q, pend_b_d;
   logic             corr_done_q, corr_done_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic             clk_local_q, clk_local_d;
   logic             bit_tick_q, bit_tick_d;
   logic             adv_ack_q, adv_ack_d;
   logic             ret_ack_q, ret_ack_d;

   logic             rise_a;
   logic             rise_b;
   logic             clr_a;
   logic             clr_b;
   logic [1:0]       step;
   logic [CNT_W:0]   sum;
   logic [CNT_W:0]   phase_ext;

   assign rise_a = a_sync_q[1] & ~a_sync_q[2];
   assign rise_b = b_sync_q[1] & ~b_sync_q[2];

   always_comb begin
      step      = 2'd1;
      clr_a     = 1'b0;
      clr_b     = 1'b0;
      adv_ack_d = 1'b0;
      ret_ack_d = 1'b0;
      // Opposing requests cancel each other and consume no correction slot.
      if (pend_a_q && pend_b_q) begin
         clr_a = 1'b1;
         clr_b = 1'b1;
      end else if (pend_a_q && !corr_done_q) begin
         step      = 2'd2;
         clr_a     = 1'b1;
         adv_ack_d = 1'b1;
      end else if (pend_b_q && !corr_done_q) begin
         step      = 2'd0;
         clr_b     = 1'b1;
         ret_ack_d = 1'b1;
      end

      sum         = {1'b0, phase_q} + (CNT_W + 1)'(step);
      phase_ext   = (sum >= DIV_W) ? (sum - DIV_W) : sum;
      phase_d     = phase_ext[CNT_W-1:0];
      bit_tick_d  = (phase_d < phase_q);
      clk_local_d = (phase_ext >= HALF_W);

      // The wrap opens a new period, so it wins over a correction applied on the same edge.
      if (bit_tick_d) begin
         corr_done_d = 1'b0;
      end else begin
         corr_done_d = corr_done_q | adv_ack_d | ret_ack_d;
      end

      pend_a_d = (pend_a_q & ~clr_a) | rise_a;
      pend_b_d = (pend_b_q & ~clr_b) | rise_b;
   end

   always_ff @(posedge clk_high or posedge rst) begin
      if (rst) begin
         a_sync_q    <= '0;
         b_sync_q    <= '0;
         pend_a_q    <= 1'b0;
         pend_b_q    <= 1'b0;
         corr_done_q <= 1'b0;
         phase_q     <= '0;
         clk_local_q <= 1'b0;
         bit_tick_q  <= 1'b0;
         adv_ack_q   <= 1'b0;
         ret_ack_q   <= 1'b0;
      end else begin
         a_sync_q    <= {a_sync_q[1:0], ahead_in};
         b_sync_q    <= {b_sync_q[1:0], behind_in};
         pend_a_q    <= pend_a_d;
         pend_b_q    <= pend_b_d;
         corr_done_q <= corr_done_d;
         phase_q     <= phase_d;
         clk_local_q <= clk_local_d;
         bit_tick_q  <= bit_tick_d;
         adv_ack_q   <= adv_ack_d;
         ret_ack_q   <= ret_ack_d;
      end
   end

   assign clk_local = clk_local_q;
   assign bit_tick  = bit_tick_q;
   assign adv_ack   = adv_ack_q;
   assign ret_ack   = ret_ack_q;
   assign phase     = phase_q;

endmodule

// File: tb/tb_bit_sync_dco.sv
// Directed bench for bit_sync_dco: period measurement between bit_tick strobes
// with hand-computed periods, phase values and acknowledge counts.
module tb_bit_sync_dco;

   logic       clk_high;
   logic       rst;
   logic       ahead_in;
   logic       behind_in;
   logic       clk_local;
   logic       bit_tick;
   logic       adv_ack;
   logic       ret_ack;
   logic [3:0] phase;

   int checks = 0;
   int errors = 0;
   int adv_total = 0;
   int ret_total = 0;
   int both_total = 0;

   bit_sync_dco #(.DIV(16), .CNT_W(4)) dut (
      .clk_high  (clk_high),
      .rst       (rst),
      .ahead_in  (ahead_in),
      .behind_in (behind_in),
      .clk_local (clk_local),
      .bit_tick  (bit_tick),
      .adv_ack   (adv_ack),
      .ret_ack   (ret_ack),
      .phase     (phase)
   );

   initial clk_high = 1'b0;
   always #5 clk_high = ~clk_high;

   always @(negedge clk_high) begin
      if (adv_ack) adv_total++;
      if (ret_ack) ret_total++;
      if (adv_ack && ret_ack) both_total++;
   end

   // Starting on a negedge, optionally pulses the inputs for one cycle (and ahead_in again
   // at cycle a2_at), then counts cycles until the next bit_tick. n = -1 on timeout.
   task automatic run_period(input logic a, input logic b, input int a2_at, output int n);
      ahead_in  = a;
      behind_in = b;
      n = 0;
      do begin
         @(negedge clk_high);
         n++;
         ahead_in  = (a2_at != 0) && (n == a2_at);
         behind_in = 1'b0;
      end while (!bit_tick && n < 64);
      if (!bit_tick) n = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ahead_in = 1'b0;
      behind_in = 1'b0;
      repeat (3) @(negedge clk_high);
      checks++;
      if ({clk_local, bit_tick, adv_ack, ret_ack, phase} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected 00000000",
                  {clk_local, bit_tick, adv_ack, ret_ack, phase});
      end
   endtask

   task automatic test_free_run();
      int exp_phase;
      int high_cnt;
      exp_phase = 0;
      high_cnt = 0;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_high);
         exp_phase = (exp_phase + 1) % 16;
         checks++;
         if (phase !== 4'(exp_phase)) begin
            errors++;
            $display("FAIL free_phase cyc %0d: got %0d, expected %0d", i, phase, exp_phase);
         end
         checks++;
         if (clk_local !== (exp_phase >= 8)) begin
            errors++;
            $display("FAIL free_clk_local cyc %0d: got %b, expected %b", i, clk_local, exp_phase >= 8);
         end
         checks++;
         if (bit_tick !== (exp_phase == 0)) begin
            errors++;
            $display("FAIL free_bit_tick cyc %0d: got %b, expected %b", i, bit_tick, exp_phase == 0);
         end
         if (i >= 16 && i < 32 && clk_local) high_cnt++;
      end
      checks++;
      if (high_cnt != 8) begin
         errors++;
         $display("FAIL free_high_cycles: got %0d, expected 8", high_cnt);
      end
   endtask

   task automatic test_advance();
      int n;
      int a0;
      run_period(1'b0, 1'b0, 0, n);
      a0 = adv_total;
      run_period(1'b1, 1'b0, 0, n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL adv_period: got %0d, expected 15", n);
      end
      run_period(1'b0, 1'b0, 0, n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL adv_next_period: got %0d, expected 16", n);
      end
      checks++;
      if (adv_total - a0 != 1 || ret_total != 0) begin
         errors++;
         $display("FAIL adv_acks: got adv %0d ret %0d, expected adv 1 ret 0", adv_total - a0, ret_total);
      end
   endtask

   task automatic test_retard();
      int n;
      int r0;
      r0 = ret_total;
      run_period(1'b0, 1'b1, 0, n);
      checks++;
      if (n != 17) begin
         errors++;
         $display("FAIL ret_period: got %0d, expected 17", n);
      end
      run_period(1'b0, 1'b0, 0, n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL ret_next_period: got %0d, expected 16", n);
      end
      checks++;
      if (ret_total - r0 != 1) begin
         errors++;
         $display("FAIL ret_acks: got %0d, expected 1", ret_total - r0);
      end
   endtask

   task automatic test_cancel();
      int n;
      int a0;
      int r0;
      a0 = adv_total;
      r0 = ret_total;
      run_period(1'b1, 1'b1, 0, n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL cancel_period: got %0d, expected 16", n);
      end
      run_period(1'b0, 1'b0, 0, n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL cancel_next_period: got %0d, expected 16", n);
      end
      checks++;
      if (adv_total != a0 || ret_total != r0) begin
         errors++;
         $display("FAIL cancel_acks: got adv %0d ret %0d, expected 0 0", adv_total - a0, ret_total - r0);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int a0;
      a0 = adv_total;
      run_period(1'b1, 1'b0, 3, n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL b2b_period_n: got %0d, expected 15", n);
      end
      checks++;
      if (adv_total - a0 != 1) begin
         errors++;
         $display("FAIL b2b_acks_n: got %0d, expected 1", adv_total - a0);
      end
      run_period(1'b0, 1'b0, 0, n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL b2b_period_n1: got %0d, expected 15", n);
      end
      checks++;
      if (adv_total - a0 != 2) begin
         errors++;
         $display("FAIL b2b_acks_n1: got %0d, expected 2", adv_total - a0);
      end
      run_period(1'b0, 1'b0, 0, n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL b2b_period_n2: got %0d, expected 16", n);
      end
   endtask

   task automatic test_wrap_and_reset();
      int n;
      int r0;
      // Pulse at cycle 12 reaches pend_a while phase is 15, so the advance lands on the wrap.
      run_period(1'b0, 1'b0, 12, n);
      checks++;
      if (n != 16 || phase !== 4'd1 || adv_ack !== 1'b1) begin
         errors++;
         $display("FAIL wrap_adv: got n=%0d phase=%0d adv_ack=%b, expected n=16 phase=1 adv_ack=1",
                  n, phase, adv_ack);
      end
      run_period(1'b0, 1'b0, 0, n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL wrap_following_period: got %0d, expected 15", n);
      end
      // pend_b is set after the third edge and would be applied on the fourth.
      behind_in = 1'b1;
      @(negedge clk_high);
      behind_in = 1'b0;
      repeat (2) @(negedge clk_high);
      rst = 1'b1;
      #1;
      checks++;
      if ({clk_local, bit_tick, adv_ack, ret_ack, phase} !== 8'h00) begin
         errors++;
         $display("FAIL midrun_reset: got %b, expected 00000000",
                  {clk_local, bit_tick, adv_ack, ret_ack, phase});
      end
      r0 = ret_total;
      repeat (2) @(negedge clk_high);
      rst = 1'b0;
      @(negedge clk_high);
      checks++;
      if (phase !== 4'd1) begin
         errors++;
         $display("FAIL post_reset_phase: got %0d, expected 1", phase);
      end
      repeat (40) @(negedge clk_high);
      checks++;
      if (ret_total != r0) begin
         errors++;
         $display("FAIL post_reset_ret_ack: got %0d, expected 0", ret_total - r0);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_advance();
      test_retard();
      test_cancel();
      test_back_to_back();
      test_wrap_and_reset();
      checks++;
      if (both_total != 0) begin
         errors++;
         $display("FAIL ack_exclusive: got %0d overlapping cycles, expected 0", both_total);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
